// File: rtl/feistel_round_sequencer_pkg.sv
// Shared types and helpers for the iterative Feistel round sequencer:
// FSM state encoding, round-count limits and key-schedule rotations.
package feistel_round_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int MAX_ROUNDS = 8;
  localparam int CNT_W      = 3;

  // Bit scramble of the 4-bit right half up to the 8-bit key width.
  function automatic logic [7:0] expand(input logic [3:0] r);
    return {r[3], r[0], r[1], r[2], r[1], r[3], r[2], r[0]};
  endfunction

  function automatic logic [7:0] rotl1(input logic [7:0] k);
    return {k[6:0], k[7]};
  endfunction

  function automatic logic [7:0] rotr1(input logic [7:0] k);
    return {k[0], k[7:1]};
  endfunction

  function automatic logic [7:0] rotl_n(input logic [7:0] k, input int n);
    logic [7:0] v;
    v = k;
    for (int i = 0; i < MAX_ROUNDS; i++) begin
      if (i < n) v = rotl1(v);
    end
    return v;
  endfunction

endpackage

// File: rtl/feistel_round_sequencer_round_f.sv
// Single-round function F(R, K): expand R, XOR with the key, then add the
// two nibbles plus key bit 0 modulo 16.
module feistel_round_f
  import feistel_round_sequencer_pkg::*;
(
  input  logic [3:0] r,
  input  logic [7:0] k,
  output logic [3:0] s
);

  logic [7:0] x;

  assign x = expand(r) ^ k;
  assign s = x[7:4] + x[3:0] + {3'b000, k[0]};

endmodule

// File: rtl/feistel_round_sequencer.sv
// Iterative Feistel wrapper: accepts a byte and key, runs ROUNDS rounds one per
// cycle, then holds the result until taken. Optional macro: FEISTEL_DECRYPT_EN.
//
// state | meaning
// IDLE  | waiting for in_valid; in_ready high
// RUN   | one round per clock, counter tracks current round
// DONE  | result on out_data, held until out_ready
module feistel_round_sequencer
  import feistel_round_sequencer_pkg::*;
#(
  parameter int ROUNDS = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic [7:0] in_key,
`ifdef FEISTEL_DECRYPT_EN
  input  logic       mode,
`endif
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       busy
);

  localparam int                LAST_INT = ROUNDS - 1;
  localparam logic [CNT_W-1:0]  LAST_RND = LAST_INT[CNT_W-1:0];

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       l_q, l_d;
  logic [3:0]       r_q, r_d;
  logic [7:0]       key_q, key_d;
  logic [3:0]       f_s;
  logic [3:0]       mix;
`ifdef FEISTEL_DECRYPT_EN
  logic             dec_q, dec_d;
`endif

  feistel_round_f u_round_f (
    .r (r_q),
    .k (key_q),
    .s (f_s)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      l_q     <= '0;
      r_q     <= '0;
      key_q   <= '0;
`ifdef FEISTEL_DECRYPT_EN
      dec_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      l_q     <= l_d;
      r_q     <= r_d;
      key_q   <= key_d;
`ifdef FEISTEL_DECRYPT_EN
      dec_q   <= dec_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    l_d     = l_q;
    r_d     = r_q;
    key_d   = key_q;
`ifdef FEISTEL_DECRYPT_EN
    dec_d   = dec_q;
`endif
    mix     = l_q ^ f_s;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = RUN;
          cnt_d   = '0;
          l_d     = in_data[7:4];
          r_d     = in_data[3:0];
          key_d   = in_key;
`ifdef FEISTEL_DECRYPT_EN
          // Decrypt starts from the last encrypt key and walks the schedule backwards.
          dec_d   = mode;
          if (mode) key_d = rotl_n(in_key, LAST_INT);
`endif
        end
      end
      RUN: begin
`ifdef FEISTEL_DECRYPT_EN
        key_d = dec_q ? rotr1(key_q) : rotl1(key_q);
`else
        key_d = rotl1(key_q);
`endif
        if (cnt_q == LAST_RND) begin
          l_d     = mix;
          state_d = DONE;
        end else begin
          l_d   = r_q;
          r_d   = mix;
          cnt_d = cnt_q + 3'd1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE) && !reset;
    out_valid = (state_q == DONE);
    busy      = (state_q != IDLE);
    out_data  = 8'h00;
    if (state_q == DONE) out_data = {l_q, r_q};
  end

endmodule

// File: tb/tb_feistel_round_sequencer.sv
// Self-checking bench: four sequencers (ROUNDS 1, 2, 4, 8) checked against a
// key-list Feistel reference model with fixed vectors and random bytes.
module tb_feistel_round_sequencer;

  localparam int N = 4;
  localparam int RV [N] = '{1, 2, 4, 8};

  logic       clock;
  logic       reset;
  logic       in_valid  [N];
  logic       in_ready  [N];
  logic [7:0] in_data   [N];
  logic [7:0] in_key    [N];
  logic       mode      [N];
  logic       out_valid [N];
  logic       out_ready [N];
  logic [7:0] out_data  [N];
  logic       busy      [N];

  int checks = 0;
  int errors = 0;

  for (genvar g = 0; g < N; g++) begin : g_dut
    feistel_round_sequencer #(.ROUNDS(RV[g])) u_dut (
      .clock     (clock),
      .reset     (reset),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .in_data   (in_data[g]),
      .in_key    (in_key[g]),
`ifdef FEISTEL_DECRYPT_EN
      .mode      (mode[g]),
`endif
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .out_data  (out_data[g]),
      .busy      (busy[g])
    );
  end

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Reference model: explicit key list, reversed for decryption.
  function automatic logic [3:0] ref_f(input logic [3:0] r, input logic [7:0] k);
    logic [7:0] e;
    logic [7:0] x;
    int sum;
    e = {r[3], r[0], r[1], r[2], r[1], r[3], r[2], r[0]};
    x = e ^ k;
    sum = (int'(x) >> 4) + (int'(x) & 15) + (int'(k) & 1);
    return 4'(sum % 16);
  endfunction

  function automatic logic [7:0] ref_cipher(input logic [7:0] d, input logic [7:0] k,
                                            input int rounds, input bit dec);
    int keys [9];
    logic [3:0] l, r, t;
    int ki;
    keys[0] = int'(k);
    for (int i = 0; i < 8; i++) keys[i+1] = ((keys[i] << 1) | (keys[i] >> 7)) & 255;
    l = d[7:4];
    r = d[3:0];
    for (int i = 0; i < rounds; i++) begin
      ki = dec ? keys[rounds-1-i] : keys[i];
      t = l ^ ref_f(r, 8'(ki));
      if (i < rounds - 1) begin
        l = r;
        r = t;
      end else begin
        l = t;
      end
    end
    return {l, r};
  endfunction

  task automatic start(input int idx, input logic [7:0] d, input logic [7:0] k, input bit dec);
    int n;
    in_data[idx]  = d;
    in_key[idx]   = k;
    mode[idx]     = dec;
    in_valid[idx] = 1'b1;
    n = 0;
    while (!in_ready[idx] && n < 50) begin
      tick();
      n++;
    end
    check_val("accept_ready", in_ready[idx], 1);
    tick();
    in_valid[idx] = 1'b0;
    in_data[idx]  = 8'($urandom);
    in_key[idx]   = 8'($urandom);
  endtask

  task automatic wait_done(input int idx, output int lat);
    lat = 0;
    while (!out_valid[idx] && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  task automatic xact(input int idx, input logic [7:0] d, input logic [7:0] k, input bit dec,
                      input logic [7:0] exp, output logic [7:0] res);
    int lat;
    start(idx, d, k, dec);
    wait_done(idx, lat);
    check_val("latency", lat, RV[idx]);
    check_val("result", out_data[idx], exp);
    res = out_data[idx];
    out_ready[idx] = 1'b1;
    tick();
    out_ready[idx] = 1'b0;
    check_val("release", {out_valid[idx], in_ready[idx]}, 2'b01);
  endtask

  // Streams nbytes with in_valid and out_ready held high; a full period is
  // ROUNDS cycles of RUN plus one DONE cycle plus one IDLE cycle.
  task automatic b2b(input int idx, input int nbytes);
    logic [7:0] exp_q [$];
    int acc, got, last, t;
    acc = 0; got = 0; last = -1; t = 0;
    out_ready[idx] = 1'b1;
    in_valid[idx]  = 1'b1;
    in_data[idx]   = 8'($urandom);
    in_key[idx]    = 8'($urandom);
    mode[idx]      = 1'b0;
    while (got < nbytes && t < nbytes * 20) begin
      if (out_valid[idx]) begin
        if (exp_q.size() == 0) check_val("b2b_spurious", 1, 0);
        else check_val("b2b_data", out_data[idx], exp_q.pop_front());
        got++;
      end
      if (acc >= nbytes) in_valid[idx] = 1'b0;
      if (in_ready[idx] && acc < nbytes) begin
        exp_q.push_back(ref_cipher(in_data[idx], in_key[idx], RV[idx], 1'b0));
        if (last >= 0) check_val("b2b_gap", t - last, RV[idx] + 2);
        last = t;
        acc++;
      end
      tick();
      t++;
      in_data[idx] = 8'($urandom);
      in_key[idx]  = 8'($urandom);
    end
    in_valid[idx]  = 1'b0;
    out_ready[idx] = 1'b0;
    check_val("b2b_count", got, nbytes);
  endtask

  initial begin
    logic [7:0] d, k, c, p, held;
    int lat;
    bit seen;

    reset = 1'b1;
    for (int i = 0; i < N; i++) begin
      in_valid[i] = 1'b0; in_data[i] = 8'h00; in_key[i] = 8'h00;
      mode[i] = 1'b0; out_ready[i] = 1'b0;
    end

    // Reset values
    tick();
    tick();
    for (int i = 0; i < N; i++) begin
      check_val("rst_in_ready", in_ready[i], 0);
      check_val("rst_out", {out_valid[i], busy[i], out_data[i]}, 10'h000);
    end
    reset = 1'b0;
    #1;
    for (int i = 0; i < N; i++) check_val("post_rst_in_ready", in_ready[i], 1);
    tick();

    // Fixed vectors
    xact(0, 8'h46, 8'h93, 1'b0, 8'h06, c);
    xact(1, 8'h46, 8'h93, 1'b0, 8'hC0, c);
`ifdef FEISTEL_DECRYPT_EN
    xact(1, 8'hC0, 8'h93, 1'b1, 8'h46, c);
`endif

    // Random bytes on every round count
    for (int i = 0; i < 256; i++) begin
      d = 8'($urandom);
      k = 8'($urandom);
      xact(2, d, k, 1'b0, ref_cipher(d, k, 4, 1'b0), c);
`ifdef FEISTEL_DECRYPT_EN
      xact(2, c, k, 1'b1, d, p);
`endif
    end
    for (int j = 0; j < N; j++) begin
      for (int i = 0; i < 12; i++) begin
        d = 8'($urandom);
        k = 8'($urandom);
        xact(j, d, k, 1'b0, ref_cipher(d, k, RV[j], 1'b0), c);
      end
    end

    // Backpressure in DONE, with a second byte offered meanwhile
    d = 8'h5A; k = 8'h3C;
    start(2, d, k, 1'b0);
    wait_done(2, lat);
    check_val("bp_latency", lat, 4);
    held = out_data[2];
    check_val("bp_data", held, ref_cipher(d, k, 4, 1'b0));
    in_valid[2] = 1'b1;
    in_data[2]  = 8'hA5;
    in_key[2]   = 8'h11;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_val("bp_hold", {out_valid[2], in_ready[2], busy[2], out_data[2]},
                {1'b1, 1'b0, 1'b1, held});
    end
    in_valid[2]  = 1'b0;
    out_ready[2] = 1'b1;
    tick();
    out_ready[2] = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid[2] || busy[2]) seen = 1'b1;
      tick();
    end
    check_val("bp_not_queued", seen, 0);
    xact(2, 8'hA5, 8'h11, 1'b0, ref_cipher(8'hA5, 8'h11, 4, 1'b0), c);

    // Reset in cycle 2 of RUN aborts the byte
    start(2, 8'h77, 8'hE1, 1'b0);
    tick();
    check_val("abort_busy_before", busy[2], 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check_val("abort_state", {out_valid[2], busy[2], in_ready[2], out_data[2]},
              {1'b0, 1'b0, 1'b1, 8'h00});
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (out_valid[2] || out_data[2] != 8'h00) seen = 1'b1;
    end
    check_val("abort_no_output", seen, 0);

    // Back-to-back with out_ready held high
    b2b(2, 10);
    b2b(0, 10);
    b2b(3, 6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
